// File: rtl/regfile_mp_pkg.sv
// Core-wide register file constants shared by decode, writeback and the register file.
// Keeps data width, register address width and the hard-wired-zero policy in one place.
package regfile_mp_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NREGS_DEF    = 32;
  localparam int REG_AW       = $clog2(NREGS_DEF);
  localparam bit ZERO_REG_DEF = 1'b1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard: set by reservation, cleared by writeback, reservation wins.
// Latency: busy updates at the next edge, busy_next is same-cycle; no backpressure.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int AW       = $clog2(NREGS),
  parameter int NWR      = 1,
  parameter bit ZERO_REG = ZERO_REG_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  output logic [NREGS-1:0]  busy,
  output logic [NREGS-1:0]  busy_next
);

  logic [NREGS-1:0] wr_hit;

  always_comb begin
    wr_hit = '0;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w]) wr_hit[wr_addr[w*AW +: AW]] = 1'b1;
    end
    // A retiring write clears first; a new writer issued in the same cycle re-arms the bit.
    busy_next = busy & ~wr_hit;
    if (rsv_en) busy_next[rsv_addr] = 1'b1;
    if (ZERO_REG) busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-first bypass and pending-write scoreboard.
// Latency: 1-cycle registered reads; no backpressure, every port is accepted every cycle.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int AW       = $clog2(NREGS),
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter bit ZERO_REG = ZERO_REG_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NWR-1:0]   wr_ok;
  logic [NREGS-1:0] busy_next;

  always_comb begin
    wr_ok = '0;
    for (int w = 0; w < NWR; w++) begin
      wr_ok[w] = wr_en[w] && !(ZERO_REG && (wr_addr[w*AW +: AW] == '0));
    end
  end

  // Ports are applied in ascending order so the higher-index port wins a collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_ok[w]) mem[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .AW       (AW),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .wr_en     (wr_ok),
    .wr_addr   (wr_addr),
    .busy      (busy_vec),
    .busy_next (busy_next)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd_next;
    logic [XLEN-1:0] rd_q;
    logic            busy_q;

    assign ra = rd_addr[i*AW +: AW];

    always_comb begin
      rd_next = mem[ra];
      for (int w = 0; w < NWR; w++) begin
        if (wr_ok[w] && (wr_addr[w*AW +: AW] == ra)) rd_next = wr_data[w*XLEN +: XLEN];
      end
      if (ZERO_REG && (ra == '0)) rd_next = '0;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_q   <= '0;
        busy_q <= 1'b0;
      end else begin
        rd_q   <= rd_next;
        busy_q <= busy_next[ra];
      end
    end

    assign rd_data[i*XLEN +: XLEN] = rd_q;
    assign rd_busy[i]              = busy_q;
  end

endmodule
